// File: rtl/systolic_result_drain_if.sv
// Row-beat stream from the result drain to the writeback/DMA path.
// The master drives each beat and its tags; the slave returns m_ready.
interface systolic_result_drain_if #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 8,
  parameter int NUM_ARRAYS = 8
);
  logic                               m_valid;
  logic                               m_ready;
  logic [ARRAY_SIZE*DATA_BITS-1:0]    m_data;
  logic [$clog2(NUM_ARRAYS)-1:0]      m_array;
  logic [$clog2(ARRAY_SIZE)-1:0]      m_row;
  logic                               m_last;

  modport master (
    output m_valid, m_data, m_array, m_row, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_array, m_row, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Walks a latched mask of systolic arrays, snapshots each array's result matrix
// and streams it out one row per beat on a valid/ready interface.
module systolic_result_drain #(
  parameter int DATA_BITS     = 16,
  parameter int ARRAY_SIZE    = 8,
  parameter int NUM_ARRAYS    = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CLEAR_AFTER   = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [NUM_ARRAYS-1:0]                    array_mask,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_BITS-1:0] results_flat,
  output logic [$clog2(NUM_ARRAYS)-1:0]            array_select,
  output logic                                     clear_acc,
  systolic_result_drain_if.master                  m,
  output logic                                     busy,
  output logic                                     done
);

  localparam int SEL_W    = $clog2(NUM_ARRAYS);
  localparam int ROW_W    = $clog2(ARRAY_SIZE);
  localparam int ROW_BITS = ARRAY_SIZE * DATA_BITS;
  localparam int CNT_W    = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  state_t                                   state;
  logic [NUM_ARRAYS-1:0]                    mask_q;
  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_BITS-1:0] snapshot;
  logic [CNT_W-1:0]                         settle_cnt;
  logic                                     empty_pass;
  logic                                     valid_q;
  logic [ROW_BITS-1:0]                      data_q;
  logic [SEL_W-1:0]                         array_q;
  logic [ROW_W-1:0]                         row_q;
  logic                                     last_q;

  logic [NUM_ARRAYS-1:0]                    mask_rest;
  logic                                     last_row;
  logic                                     beat;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_ARRAYS-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ARRAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  assign mask_rest = mask_q & ~(NUM_ARRAYS'(1) << array_select);
  assign last_row  = (row_q == ROW_W'(ARRAY_SIZE - 1));
  assign beat      = valid_q & m.m_ready;

  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_array = array_q;
  assign m.m_row   = row_q;
  assign m.m_last  = last_q;

  // An empty mask spends one extra DONE cycle with done low, so done still
  // lands two cycles after the accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mask_q       <= '0;
      snapshot     <= '0;
      settle_cnt   <= '0;
      empty_pass   <= 1'b0;
      array_select <= '0;
      clear_acc    <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      array_q      <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      clear_acc <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= array_mask;
            busy   <= 1'b1;
            if (|array_mask) begin
              array_select <= lowest_set(array_mask);
              settle_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state        <= SELECT;
            end else begin
              empty_pass <= 1'b1;
              state      <= DONE;
            end
          end
        end
        SELECT: begin
          if (settle_cnt == '0) begin
            clear_acc <= (CLEAR_AFTER != 0);
            state     <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          snapshot <= results_flat;
          mask_q   <= mask_rest;
          data_q   <= results_flat[ROW_BITS-1:0];
          array_q  <= array_select;
          row_q    <= '0;
          last_q   <= 1'b0;
          valid_q  <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (beat) begin
            if (last_row) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              row_q   <= '0;
              if (|mask_q) begin
                array_select <= lowest_set(mask_q);
                settle_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                state        <= SELECT;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              row_q  <= row_q + 1'b1;
              data_q <= snapshot[(int'(row_q) + 1) * ROW_BITS +: ROW_BITS];
              last_q <= (row_q == ROW_W'(ARRAY_SIZE - 2)) && (mask_q == '0);
            end
          end
        end
        DONE: begin
          if (empty_pass) begin
            empty_pass <= 1'b0;
            done       <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
